// File: rtl/fnd_pkg.sv
// Shared constants, font table and FSM state type for the FND display blocks.
package fnd_pkg;

  localparam int FND_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam int BIN_W      = 14;
  localparam int DD_STEPS   = 14;
  localparam logic [BIN_W-1:0] MAX_DISPLAY = 14'd9999;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [7:0] FONT_DASH  = 8'hBF;

  typedef enum logic {ST_IDLE, ST_CONV} fnd_state_e;

  // Double-dabble pre-shift correction: any nibble >= 5 gets +3.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] i_bcd);
    logic [BCD_W-1:0] v;
    v = i_bcd;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (v[n*4 +: 4] >= 4'd5) v[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
    end
    return v;
  endfunction

endpackage

// File: rtl/fnd_font_decode.sv
// BCD nibble to common-anode 7-segment font (active-low, dp off).
// Dash takes priority over blank so overflow indication is never hidden.
module fnd_font_decode
  import fnd_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [7:0] o_font
);

  always_comb begin
    o_font = FONT_BLANK;
    if (i_dash) begin
      o_font = FONT_DASH;
    end else if (!i_blank) begin
      case (i_nibble)
        4'd0:    o_font = FONT_0;
        4'd1:    o_font = FONT_1;
        4'd2:    o_font = FONT_2;
        4'd3:    o_font = FONT_3;
        4'd4:    o_font = FONT_4;
        4'd5:    o_font = FONT_5;
        4'd6:    o_font = FONT_6;
        4'd7:    o_font = FONT_7;
        4'd8:    o_font = FONT_8;
        4'd9:    o_font = FONT_9;
        default: o_font = FONT_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan driver with sequential binary-to-BCD conversion.
// Define FND_LZB_EN to blank leading zeros (digit 0 and dashes never blanked).
//
// state   | meaning
// ST_IDLE | waiting for i_Load; display register holds last commit
// ST_CONV | 14 double-dabble shifts in flight, o_Busy high
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [BIN_W-1:0] i_Value,
  input  logic             i_Load,
  input  logic             i_EN,
  output logic             o_Busy,
  output logic [3:0]       o_FND_Digit,
  output logic [7:0]       o_FND_Font
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  fnd_state_e       r_state, w_state_nxt;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_scratch, r_disp;
  logic [3:0]       r_step;
  logic             r_ovf_pend, r_ovf, r_busy;
  logic [PW-1:0]    r_presc;
  logic [1:0]       r_idx;
  logic [3:0]       r_digit;
  logic [7:0]       r_font;

  logic [BCD_W-1:0] w_adj, w_shifted, w_upper;
  logic             w_last, w_blank;
  logic [7:0]       w_font;

  assign w_adj     = dd_adjust(r_scratch);
  assign w_shifted = (w_adj << 1) | BCD_W'(r_bin[BIN_W-1]);
  assign w_last    = (r_step == 4'(DD_STEPS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_Load) w_state_nxt = ST_CONV;
      ST_CONV: if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_bin      <= '0;
      r_scratch  <= '0;
      r_step     <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_Load) begin
            r_bin      <= i_Value;
            r_scratch  <= '0;
            r_step     <= '0;
            r_ovf_pend <= (i_Value > MAX_DISPLAY);
            r_busy     <= 1'b1;
          end
        end
        ST_CONV: begin
          r_bin     <= r_bin << 1;
          r_scratch <= w_shifted;
          r_step    <= r_step + 4'd1;
          if (w_last) begin
            r_busy <= 1'b0;
            // Out-of-range values keep the old digits; only the flag changes.
            if (r_ovf_pend) begin
              r_ovf <= 1'b1;
            end else begin
              r_ovf  <= 1'b0;
              r_disp <= w_shifted;
            end
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_upper = r_disp >> {r_idx, 2'b00};
`ifdef FND_LZB_EN
  assign w_blank = (r_idx != 2'd0) && (w_upper == '0);
`else
  assign w_blank = 1'b0;
`endif

  fnd_font_decode u_font (
    .i_nibble (w_upper[3:0]),
    .i_blank  (w_blank),
    .i_dash   (r_ovf),
    .o_font   (w_font)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_EN) begin
      r_digit <= 4'hF;
      r_font  <= FONT_BLANK;
    end else begin
      r_digit <= ~(4'b0001 << r_idx);
      r_font  <= w_font;
    end
  end

  assign o_Busy      = r_busy;
  assign o_FND_Digit = r_digit;
  assign o_FND_Font  = r_font;

endmodule
